// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and bit-timing helpers.
// Used by uart_rx and uart_tx.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  function automatic int cyclesPerBit(input int clkHz, input int bitRate);
    return clkHz / bitRate;
  endfunction

  function automatic int counterWidth(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchronizer that resets to 1, for idle-high asynchronous inputs
// such as the UART line or active-low push buttons.
module uart_rx_sync #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_async,
  output logic o_sync
);

  logic [DEPTH-1:0] r_stages;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stages <= '1;
    end else begin
      r_stages <= {r_stages[DEPTH-2:0], i_async};
    end
  end

  assign o_sync = r_stages[DEPTH-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 by default, mid-bit sampling with framing/break detection.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BIT_RATE     = 115200,
  parameter int PAYLOAD_BITS = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_valid,
  output logic                    uart_rx_frame_err,
  output logic                    uart_rx_break,
  output logic                    uart_rx_parity_err
);

  localparam int CYCLES_PER_BIT = cyclesPerBit(CLK_HZ, BIT_RATE);
  localparam int CNT_W          = counterWidth(CYCLES_PER_BIT);
  localparam int IDX_W          = $clog2(PAYLOAD_BITS + 1);

  localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_CYCLE = CNT_W'(CYCLES_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] LAST_BIT   = IDX_W'(PAYLOAD_BITS - 1);

  uart_state_t             r_state;
  logic [CNT_W-1:0]        r_cycleCnt;
  logic [IDX_W-1:0]        r_bitIdx;
  logic [PAYLOAD_BITS-1:0] r_shift;
  logic [PAYLOAD_BITS-1:0] r_data;
  logic                    r_armed;
  logic                    r_valid;
  logic                    r_frameErr;
  logic                    r_break;
  logic                    w_rxs;
  logic                    w_allZero;
  logic                    w_bitDone;
`ifdef UART_RX_PARITY_EN
  logic                    r_parityBit;
  logic                    r_parityErr;
`endif

  uart_rx_sync #(
    .DEPTH(2)
  ) u_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .i_async(uart_rxd),
    .o_sync (w_rxs)
  );

  assign w_bitDone = (r_cycleCnt == LAST_CYCLE);

`ifdef UART_RX_PARITY_EN
  assign w_allZero = (r_shift == '0) && !r_parityBit;
`else
  assign w_allZero = (r_shift == '0);
`endif

  // Shifting in at the MSB end lands the LSB-first bits at their own index
  // once the whole payload has been taken.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_cycleCnt <= '0;
      r_bitIdx   <= '0;
      r_shift    <= '0;
      r_data     <= '0;
      r_armed    <= 1'b0;
      r_valid    <= 1'b0;
      r_frameErr <= 1'b0;
      r_break    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parityBit <= 1'b0;
      r_parityErr <= 1'b0;
`endif
    end else begin
      r_valid    <= 1'b0;
      r_frameErr <= 1'b0;
      r_break    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parityErr <= 1'b0;
`endif
      if (r_state != IDLE && !uart_rx_en) begin
        r_state    <= IDLE;
        r_armed    <= 1'b0;
        r_cycleCnt <= '0;
        r_bitIdx   <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_rxs) begin
              r_armed <= 1'b1;
            end
            if (r_armed && uart_rx_en && !w_rxs) begin
              r_state    <= START;
              r_cycleCnt <= '0;
            end
          end
          START: begin
            if (r_cycleCnt == HALF_CYCLE) begin
              r_cycleCnt <= '0;
              r_bitIdx   <= '0;
              r_state    <= w_rxs ? IDLE : DATA;
            end else begin
              r_cycleCnt <= r_cycleCnt + 1'b1;
            end
          end
          DATA: begin
            if (w_bitDone) begin
              r_cycleCnt <= '0;
              r_shift    <= {w_rxs, r_shift[PAYLOAD_BITS-1:1]};
              if (r_bitIdx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                r_state <= PARITY;
`else
                r_state <= STOP;
`endif
              end else begin
                r_bitIdx <= r_bitIdx + 1'b1;
              end
            end else begin
              r_cycleCnt <= r_cycleCnt + 1'b1;
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (w_bitDone) begin
              r_cycleCnt  <= '0;
              r_parityBit <= w_rxs;
              r_state     <= STOP;
            end else begin
              r_cycleCnt <= r_cycleCnt + 1'b1;
            end
          end
`endif
          // Leaving at mid-stop-bit keeps half a bit of idle time in which to
          // re-arm, so an immediately following start bit is still caught.
          STOP: begin
            if (w_bitDone) begin
              r_cycleCnt <= '0;
              r_state    <= IDLE;
              r_armed    <= 1'b0;
              if (w_rxs) begin
`ifdef UART_RX_PARITY_EN
                if (^{r_shift, r_parityBit}) begin
                  r_parityErr <= 1'b1;
                end else begin
                  r_data  <= r_shift;
                  r_valid <= 1'b1;
                end
`else
                r_data  <= r_shift;
                r_valid <= 1'b1;
`endif
              end else begin
                r_frameErr <= 1'b1;
                r_break    <= w_allZero;
              end
            end else begin
              r_cycleCnt <= r_cycleCnt + 1'b1;
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign uart_rx_data      = r_data;
  assign uart_rx_valid     = r_valid;
  assign uart_rx_frame_err = r_frameErr;
  assign uart_rx_break     = r_break;
`ifdef UART_RX_PARITY_EN
  assign uart_rx_parity_err = r_parityErr;
`else
  assign uart_rx_parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Asynchronous serial receiver, 8N1 by default. It is the receive end of the board's UART link and the counterpart of uart_tx. It samples uart_rxd at mid-bit and presents each received word with a one-cycle valid pulse. It flags framing errors and line breaks. It sits beside uart_tx in the top level so the board can accept operands from a host.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz.
- BIT_RATE, 115200, line rate in bit/s. CYCLES_PER_BIT = CLK_HZ / BIT_RATE (integer division, 434 at defaults).
- PAYLOAD_BITS, 8, data bits per frame, sent LSB first.

Ports:
- clk, input, 1, system clock; all logic is on the rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- uart_rxd, input, 1, serial line; idle level is high; asynchronous to clk.
- uart_rx_en, input, 1, receive enable.
- uart_rx_data, output, PAYLOAD_BITS, last correctly received word.
- uart_rx_valid, output, 1, one-cycle pulse when uart_rx_data is updated.
- uart_rx_frame_err, output, 1, one-cycle pulse when the stop bit samples low.
- uart_rx_break, output, 1, one-cycle pulse when a frame is all zeros including the stop bit.
- uart_rx_parity_err, output, 1, one-cycle parity-mismatch pulse; tied to 0 without the optional feature.

Behaviour:
- Synchronizer:
  - uart_rxd passes through a 2-flop synchronizer; both flops reset to 1.
  - All decisions use the synchronized signal rxs.
- Reset values: uart_rx_data = 0; all pulse outputs = 0; state = IDLE; bit counter and cycle counter = 0.
- IDLE:
  - Armed only if rxs has been seen high since the last frame ended.
  - If armed, uart_rx_en = 1 and rxs = 0, go to START and clear the cycle counter.
- START:
  - After CYCLES_PER_BIT/2 cycles, sample rxs.
  - rxs = 0: go to DATA, clear the cycle counter and bit index.
  - rxs = 1: glitch rejected, return to IDLE, no output.
- DATA:
  - Every CYCLES_PER_BIT cycles, sample rxs into a shift register at index bit_idx, LSB first.
  - After PAYLOAD_BITS samples, go to PARITY if enabled, otherwise STOP.
- STOP:
  - After CYCLES_PER_BIT cycles, sample rxs.
  - rxs = 1: load uart_rx_data from the shift register and pulse uart_rx_valid in the next cycle.
  - rxs = 0: pulse uart_rx_frame_err; uart_rx_data is unchanged. If the shift register is also all zeros, pulse uart_rx_break as well.
  - In both cases return to IDLE, disarmed until rxs is seen high.
- Latency: uart_rx_valid rises 2 + CYCLES_PER_BIT/2 + (PAYLOAD_BITS+1)·CYCLES_PER_BIT + 1 cycles after the falling edge on uart_rxd (±1 cycle of synchronizer phase).
- Back-to-back frames: a start bit that begins immediately after the stop bit must be accepted. The receiver returns to IDLE at mid-stop-bit, so no frame is lost.
- uart_rx_en deasserted mid-frame: abort to IDLE at once; no pulses, uart_rx_data held.
- reset_n asserted mid-frame: immediate return to reset values; the partial word is discarded.
- uart_rx_data is held stable between valid pulses. At most one pulse output is high in any cycle, except frame_err together with break.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - A PARITY state follows DATA and samples one bit after CYCLES_PER_BIT cycles.
  - Parity is even: the XOR of the data bits and the parity bit must be 0.
  - On mismatch, uart_rx_parity_err pulses together with the stop-bit decision, and uart_rx_valid is suppressed for that frame.
- Undefined: no PARITY state; uart_rx_parity_err is constant 0.

Decomposition:
- Package uart_pkg:
  - state enum {IDLE, START, DATA, PARITY, STOP};
  - constant function for CYCLES_PER_BIT and the counter width ($clog2(CYCLES_PER_BIT+1)).
  - uart_tx shares the package.
- Sub-module uart_rx_sync: parameterised-depth (default 2) reset-to-1 synchronizer; reusable for the save_a_n/save_b_n buttons.

Test Plan (CLK_HZ=1_000_000, BIT_RATE=100_000, so 10 cycles/bit):
- Single frame 0xA5 with stop bit = 1 -> exactly one uart_rx_valid pulse, uart_rx_data = 0xA5, about 97 cycles after the start edge; no error pulses.
- Back-to-back 0x00 then 0xFF with no idle gap -> two valid pulses about 100 cycles apart, data 0x00 then 0xFF.
- 3-cycle low glitch on an idle line -> no pulses; state back in IDLE; a following frame 0x3C is received correctly.
- Frame 0x3C with stop bit = 0 -> uart_rx_frame_err pulse, no valid, uart_rx_data keeps its previous value. Line held low for 30 bits -> one frame_err + break pulse only, then re-arm after the line returns high.
- reset_n pulsed low at bit 4 of frame 0x5A, then frame 0x81 -> outputs at reset values, then valid with 0x81 only.
- Loopback from uart_tx at the same parameters, words 0x00..0x1F (with UART_RX_PARITY_EN, inject a flipped parity bit on 0x1F) -> every word matches; the flipped frame gives a parity_err pulse and no valid.
